// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction / data) arbiter in front of a single
// shared memory port. Each requester owns a one-deep pending register; an FSM
// issues one transaction at a time, pulses mem_valid for one cycle and routes
// the memory response back to the owning requester.

package mem_arbiter_pkg;

  // Request bundle as seen by (and forwarded to) the memory.
  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  // Response bundle returned by the memory.
  typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_ready;
  } mem_out_type;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } arb_state_t;

endpackage : mem_arbiter_pkg

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  // 1: alternate grants under contention; 0: data port always wins.
  parameter bit round_robin = 1'b1
) (
  input  logic        rst,
  input  logic        clk,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  mem_in,
  input  mem_out_type mem_out
);

  arb_state_t state;
  mem_in_type i_pend;   // instruction-side pending request
  mem_in_type d_pend;   // data-side pending request
  mem_in_type req_q;    // issued request, drives mem_in directly
  logic       last_d;   // 1 when the most recent grant went to the data port

  mem_in_type i_req;    // effective instruction request this cycle
  mem_in_type d_req;    // effective data request this cycle
  logic       grant_i;
  logic       grant_d;

  // Arbitration: a request arriving this cycle takes precedence over (and
  // replaces) the stored one, which gives the one-cycle request-to-issue path.
  always_comb begin
    // NOTE: every output of an always_comb gets a default first so that no
    // path leaves it unassigned; otherwise a latch would be inferred.
    i_req   = imem_in.mem_valid ? imem_in : i_pend;
    d_req   = dmem_in.mem_valid ? dmem_in : d_pend;
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (i_req.mem_valid && d_req.mem_valid) begin
        // Contention: round robin favours whoever was not served last.
        if (round_robin && last_d) begin
          grant_i = 1'b1;
        end else begin
          grant_d = 1'b1;
        end
      end else begin
        grant_i = i_req.mem_valid;
        grant_d = d_req.mem_valid;
      end
    end
  end

  // Pending registers: capture every valid request, drop the entry once granted.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge regardless of block order.
    if (!rst) begin
      i_pend <= '0;
      d_pend <= '0;
    end else begin
      if (grant_i) begin
        i_pend.mem_valid <= 1'b0;
      end else if (imem_in.mem_valid) begin
        i_pend <= imem_in;
      end

      if (grant_d) begin
        d_pend.mem_valid <= 1'b0;
      end else if (dmem_in.mem_valid) begin
        d_pend <= dmem_in;
      end
    end
  end

  // Control FSM: issue a grant from IDLE, wait for mem_ready in the busy state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      req_q  <= '0;
      last_d <= 1'b0;
    end else begin
      // mem_valid is a single-cycle pulse; the other fields are held.
      req_q.mem_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state  <= DBUSY;
            req_q  <= d_req;
            last_d <= 1'b1;
          end else if (grant_i) begin
            state  <= IBUSY;
            req_q  <= i_req;
            last_d <= 1'b0;
          end
        end
        IBUSY, DBUSY: begin
          if (mem_out.mem_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Response routing: only the current owner sees the memory response, and
  // a ready arriving while idle is dropped.
  always_comb begin
    imem_out = '0;
    dmem_out = '0;
    if (mem_out.mem_ready) begin
      if (state == IBUSY) begin
        imem_out = mem_out;
      end else if (state == DBUSY) begin
        dmem_out = mem_out;
      end
    end
  end

  assign mem_in = req_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. One instance uses round robin, a second
// uses fixed data priority. Inputs change 1 time unit after the rising edge;
// outputs are checked after a further settle delay.

module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk;
  logic        rst;

  mem_in_type  imem_in, dmem_in, mem_in;
  mem_out_type imem_out, dmem_out, mem_out;

  mem_in_type  f_imem_in, f_dmem_in, f_mem_in;
  mem_out_type f_imem_out, f_dmem_out, f_mem_out;

  int n_checks;
  int n_fail;

  mem_arbiter #(.round_robin(1'b1)) dut (
    .rst      (rst),
    .clk      (clk),
    .imem_in  (imem_in),
    .imem_out (imem_out),
    .dmem_in  (dmem_in),
    .dmem_out (dmem_out),
    .mem_in   (mem_in),
    .mem_out  (mem_out)
  );

  mem_arbiter #(.round_robin(1'b0)) dut_fp (
    .rst      (rst),
    .clk      (clk),
    .imem_in  (f_imem_in),
    .imem_out (f_imem_out),
    .dmem_in  (f_dmem_in),
    .dmem_out (f_dmem_out),
    .mem_in   (f_mem_in),
    .mem_out  (f_mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the directed sequence is short; anything this long is a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  function automatic mem_in_type mk_req(input logic fence, input logic instr,
                                        input logic [31:0] addr,
                                        input logic [31:0] wdata,
                                        input logic [3:0] wstrb);
    mem_in_type r;
    r.mem_valid = 1'b1;
    r.mem_fence = fence;
    r.mem_instr = instr;
    r.mem_addr  = addr;
    r.mem_wdata = wdata;
    r.mem_wstrb = wstrb;
    return r;
  endfunction

  function automatic mem_out_type mk_rsp(input logic [31:0] rdata);
    mem_out_type r;
    r.mem_rdata = rdata;
    r.mem_ready = 1'b1;
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    imem_in   = '0;
    dmem_in   = '0;
    mem_out   = '0;
    f_imem_in = '0;
    f_dmem_in = '0;
    f_mem_out = '0;
  endtask

  // Hold reset for two cycles with a stray memory response present, check
  // that every output is zero, then release away from the clock edge.
  task automatic do_reset();
    clear_inputs();
    rst     = 1'b0;
    mem_out = mk_rsp(32'hCAFE_F00D);
    next_cycle();
    next_cycle();
    check("rst_mem_in",   mem_in,   '0);
    check("rst_imem_out", imem_out, '0);
    check("rst_dmem_out", dmem_out, '0);
    check("rst_fp_mem_in", f_mem_in, '0);
    mem_out = '0;
    rst     = 1'b1;
    next_cycle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    clear_inputs();

    // ---------------- Single instruction request ----------------
    do_reset();
    imem_in = mk_req(1'b0, 1'b1, 32'h100, 32'h0, 4'h0);       // cycle 0
    settle();
    check("single_c0_valid", mem_in.mem_valid, 1'b0);
    next_cycle();                                              // cycle 1
    imem_in = '0;
    settle();
    check("single_c1_valid", mem_in.mem_valid, 1'b1);
    check("single_c1_addr",  mem_in.mem_addr,  32'h100);
    check("single_c1_instr", mem_in.mem_instr, 1'b1);
    next_cycle();                                              // cycle 2
    check("single_c2_valid", mem_in.mem_valid, 1'b0);
    check("single_c2_addr",  mem_in.mem_addr,  32'h100);
    check("single_c2_iready", imem_out.mem_ready, 1'b0);
    next_cycle();                                              // cycle 3
    mem_out = mk_rsp(32'hDEAD_BEEF);
    settle();
    check("single_c3_iready", imem_out.mem_ready, 1'b1);
    check("single_c3_irdata", imem_out.mem_rdata, 32'hDEAD_BEEF);
    check("single_c3_dmem",   dmem_out, '0);
    next_cycle();                                              // cycle 4, IDLE
    mem_out = '0;
    settle();
    check("single_c4_imem", imem_out, '0);
    check("single_c4_valid", mem_in.mem_valid, 1'b0);

    // ---------------- Contention, round robin, 1-cycle memory ----------------
    do_reset();
    imem_in = mk_req(1'b0, 1'b1, 32'h200, 32'h0, 4'h0);        // cycle 0
    dmem_in = mk_req(1'b0, 1'b0, 32'h8000, 32'hA5A5_0001, 4'h3);
    next_cycle();                                              // cycle 1
    imem_in = '0;
    dmem_in = '0;
    mem_out = mk_rsp(32'h1111_1111);
    settle();
    check("cont_c1_valid", mem_in.mem_valid, 1'b1);
    check("cont_c1_addr",  mem_in.mem_addr,  32'h8000);
    check("cont_c1_wdata", mem_in.mem_wdata, 32'hA5A5_0001);
    check("cont_c1_wstrb", mem_in.mem_wstrb, 4'h3);
    check("cont_c1_dready", dmem_out.mem_ready, 1'b1);
    check("cont_c1_drdata", dmem_out.mem_rdata, 32'h1111_1111);
    check("cont_c1_imem",  imem_out, '0);
    next_cycle();                                              // cycle 2, IDLE
    mem_out = '0;
    settle();
    check("cont_c2_valid", mem_in.mem_valid, 1'b0);
    check("cont_c2_dmem",  dmem_out, '0);
    next_cycle();                                              // cycle 3
    mem_out = mk_rsp(32'h2222_2222);
    settle();
    check("cont_c3_valid", mem_in.mem_valid, 1'b1);
    check("cont_c3_addr",  mem_in.mem_addr,  32'h200);
    check("cont_c3_instr", mem_in.mem_instr, 1'b1);
    check("cont_c3_iready", imem_out.mem_ready, 1'b1);
    check("cont_c3_irdata", imem_out.mem_rdata, 32'h2222_2222);
    check("cont_c3_dmem",  dmem_out, '0);
    next_cycle();
    mem_out = '0;

    // ---------------- Continuous contention alternates strictly ----------------
    do_reset();
    imem_in = mk_req(1'b0, 1'b1, 32'h400, 32'h0, 4'h0);
    dmem_in = mk_req(1'b0, 1'b0, 32'h9000, 32'h0, 4'hF);
    for (int t = 0; t < 4; t++) begin
      next_cycle();                                            // issue cycle
      mem_out = mk_rsp(32'h3000 + 32'(t));
      settle();
      check("rr_valid", mem_in.mem_valid, 1'b1);
      if (t % 2 == 0) begin
        check("rr_addr_d", mem_in.mem_addr, 32'h9000);
        check("rr_dready", dmem_out.mem_ready, 1'b1);
        check("rr_imem0",  imem_out, '0);
      end else begin
        check("rr_addr_i", mem_in.mem_addr, 32'h400);
        check("rr_iready", imem_out.mem_ready, 1'b1);
        check("rr_dmem0",  dmem_out, '0);
      end
      next_cycle();                                            // IDLE cycle
      mem_out = '0;
      settle();
      check("rr_idle_valid", mem_in.mem_valid, 1'b0);
    end

    // ---------------- Pending overwrite ----------------
    do_reset();
    dmem_in = mk_req(1'b0, 1'b0, 32'hA000, 32'h0, 4'h1);       // cycle 0
    next_cycle();                                              // cycle 1, DBUSY
    dmem_in = '0;
    imem_in = mk_req(1'b0, 1'b1, 32'h300, 32'h0, 4'h0);
    settle();
    check("ovr_c1_addr", mem_in.mem_addr, 32'hA000);
    next_cycle();                                              // cycle 2
    imem_in = mk_req(1'b0, 1'b1, 32'h304, 32'h0, 4'h0);
    settle();
    check("ovr_c2_addr_held", mem_in.mem_addr, 32'hA000);
    next_cycle();                                              // cycle 3
    imem_in = '0;
    mem_out = mk_rsp(32'h4444_4444);
    settle();
    check("ovr_c3_dready", dmem_out.mem_ready, 1'b1);
    check("ovr_c3_imem",   imem_out, '0);
    next_cycle();                                              // cycle 4, IDLE
    mem_out = '0;
    settle();
    check("ovr_c4_valid", mem_in.mem_valid, 1'b0);
    next_cycle();                                              // cycle 5
    mem_out = mk_rsp(32'h5555_5555);
    settle();
    check("ovr_c5_valid", mem_in.mem_valid, 1'b1);
    check("ovr_c5_addr",  mem_in.mem_addr,  32'h304);
    check("ovr_c5_iready", imem_out.mem_ready, 1'b1);
    next_cycle();                                              // cycle 6, IDLE
    mem_out = '0;
    next_cycle();                                              // cycle 7
    check("ovr_c7_no_reissue", mem_in.mem_valid, 1'b0);

    // ---------------- Fence ----------------
    do_reset();
    imem_in = mk_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);           // cycle 0
    next_cycle();                                              // cycle 1
    imem_in = '0;
    mem_out = mk_rsp(32'h0);
    settle();
    check("fence_valid", mem_in.mem_valid, 1'b1);
    check("fence_flag",  mem_in.mem_fence, 1'b1);
    check("fence_addr",  mem_in.mem_addr,  32'h0);
    check("fence_iready", imem_out.mem_ready, 1'b1);
    check("fence_dmem",  dmem_out, '0);
    next_cycle();
    mem_out = '0;
    settle();
    check("fence_after_valid", mem_in.mem_valid, 1'b0);

    // ---------------- Reset mid-transaction ----------------
    do_reset();
    dmem_in = mk_req(1'b0, 1'b0, 32'hB000, 32'h1234_5678, 4'hF); // cycle 0
    next_cycle();                                              // cycle 1
    dmem_in = '0;
    settle();
    check("mrst_c1_valid", mem_in.mem_valid, 1'b1);
    check("mrst_c1_wdata", mem_in.mem_wdata, 32'h1234_5678);
    next_cycle();                                              // cycle 2, DBUSY
    rst     = 1'b0;
    mem_out = mk_rsp(32'h7777_7777);
    settle();
    check("mrst_in_rst_mem_in", mem_in,   '0);
    check("mrst_in_rst_dmem",   dmem_out, '0);
    check("mrst_in_rst_imem",   imem_out, '0);
    next_cycle();
    rst = 1'b1;                                                // stray ready still high
    settle();
    check("mrst_stray_dmem",  dmem_out, '0);
    check("mrst_stray_imem",  imem_out, '0);
    check("mrst_stray_valid", mem_in.mem_valid, 1'b0);
    next_cycle();
    mem_out = '0;
    imem_in = mk_req(1'b0, 1'b1, 32'h600, 32'h0, 4'h0);
    settle();
    check("mrst_idle_valid", mem_in.mem_valid, 1'b0);
    next_cycle();
    imem_in = '0;
    settle();
    check("mrst_new_valid", mem_in.mem_valid, 1'b1);
    check("mrst_new_addr",  mem_in.mem_addr,  32'h600);
    next_cycle();
    mem_out = mk_rsp(32'h0);
    next_cycle();
    mem_out = '0;

    // ---------------- Fixed priority (second instance) ----------------
    do_reset();
    f_imem_in = mk_req(1'b0, 1'b1, 32'h500, 32'h0, 4'h0);
    f_dmem_in = mk_req(1'b0, 1'b0, 32'hC000, 32'h0, 4'hF);
    for (int t = 0; t < 4; t++) begin
      next_cycle();                                            // issue cycle
      f_mem_out = mk_rsp(32'h6000 + 32'(t));
      settle();
      check("fp_valid",  f_mem_in.mem_valid, 1'b1);
      check("fp_addr",   f_mem_in.mem_addr,  32'hC000);
      check("fp_dready", f_dmem_out.mem_ready, 1'b1);
      check("fp_imem0",  f_imem_out, '0);
      next_cycle();                                            // IDLE cycle
      f_mem_out = '0;
    end
    clear_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_arbiter
